// File: rtl/guess_entry.sv
// guess_entry: synchronises and debounces the enter button, samples the
// switches as a 4-digit BCD guess, validates it and either offers it to the
// game logic over valid/ready or pulses an error with a cause code.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter,
  input  logic [15:0] SW,
  input  logic        guess_ready,
  output logic        guess_valid,
  output logic [15:0] guess,
  output logic        guess_error,
  output logic [1:0]  error_code,
  output logic        busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OFFER
  } state_t;

  logic [SYNC_STAGES-1:0]       enter_sync;
  logic [SYNC_STAGES-1:0][15:0] sw_sync;
  logic                         enter_s;
  logic [15:0]                  sw_s;

  logic [CW-1:0] db_cnt;
  logic          db_level;
  logic          db_prev;
  logic          press;

  state_t state_q, state_d;
  logic   capture;
  logic   range_bad;
  logic   dup_bad;
  logic   guess_bad;

  assign enter_s = enter_sync[SYNC_STAGES-1];
  assign sw_s    = sw_sync[SYNC_STAGES-1];

  // Synchroniser chains for the button and the switch bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enter_sync <= '0;
      sw_sync    <= '0;
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], enter};
      sw_sync    <= {sw_sync[SYNC_STAGES-2:0], SW};
    end
  end

  // Debounce: the level follows the synced input only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (enter_s != db_level) begin
      if (db_cnt == CNT_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered rising-edge detect of the debounced level: one-cycle press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_prev <= 1'b0;
      press   <= 1'b0;
    end else begin
      db_prev <= db_level;
      press   <= db_level & ~db_prev;
    end
  end

  // Guess validation on the captured register: range and pairwise distinctness.
  always_comb begin
    range_bad = (guess[15:12] > 4'd9) || (guess[11:8] > 4'd9) ||
                (guess[7:4]   > 4'd9) || (guess[3:0]  > 4'd9);
    dup_bad   = (guess[15:12] == guess[11:8]) || (guess[15:12] == guess[7:4]) ||
                (guess[15:12] == guess[3:0])  || (guess[11:8]  == guess[7:4]) ||
                (guess[11:8]  == guess[3:0])  || (guess[7:4]   == guess[3:0]);
    guess_bad = range_bad | dup_bad;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; presses outside IDLE are simply ignored.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = guess_bad ? IDLE : OFFER;
      end
      OFFER: begin
        if (guess_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Guess latch: only a press in IDLE loads a new value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      guess <= '0;
    end else if (capture) begin
      guess <= sw_s;
    end
  end

  // Error pulse and sticky cause code, registered out of CHECK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      guess_error <= 1'b0;
      error_code  <= '0;
    end else begin
      guess_error <= 1'b0;
      if (state_q == CHECK && guess_bad) begin
        guess_error <= 1'b1;
        error_code  <= {dup_bad, range_bad};
      end
    end
  end

  assign guess_valid = (state_q == OFFER);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboard bench for guess_entry with a small debounce for fast runs.
module tb_guess_entry;

  localparam int DEB = 4;
  localparam int SYN = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter;
  logic [15:0] SW;
  logic        guess_ready;
  logic        guess_valid;
  logic [15:0] guess;
  logic        guess_error;
  logic [1:0]  error_code;
  logic        busy;

  guess_entry #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYN)) dut (
    .clock      (clock),
    .reset      (reset),
    .enter      (enter),
    .SW         (SW),
    .guess_ready(guess_ready),
    .guess_valid(guess_valid),
    .guess      (guess),
    .guess_error(guess_error),
    .error_code (error_code),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Ready source: 0 low, 1 high, 2 random per cycle.
  int rmode = 0;
  bit rbit  = 1'b0;
  always @(posedge clock) begin
    #1;
    rbit = 1'($urandom_range(0, 1));
  end
  assign guess_ready = (rmode == 1) || (rmode == 2 && rbit);

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] last_code = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a guess is accepted iff all four digits are decimal and distinct.
  function automatic exp_t model(input logic [15:0] sw, input int c);
    exp_t e;
    int   d[4];
    bit   rng = 1'b0;
    bit   dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = int'((sw >> (4 * i)) & 16'hF);
      if (d[i] > 9) rng = 1'b1;
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (d[i] == d[j]) dup = 1'b1;
    e.is_err = rng || dup;
    e.val    = sw;
    e.code   = {dup, rng};
    e.cyc    = c;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT offers, transfers or errors.
  bit          vprev = 1'b0;
  bit          eprev = 1'b0;
  bit          post_xfer = 1'b0;
  logic [15:0] offered = '0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      vprev     = 1'b0;
      eprev     = 1'b0;
      post_xfer = 1'b0;
    end else begin
      if (post_xfer) begin
        chk("valid_after_xfer", guess_valid, 0);
        chk("busy_after_xfer", busy, 0);
        post_xfer = 1'b0;
      end
      if (eprev) chk("error_pulse_width", guess_error, 0);
      if (guess_valid && !vprev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got guess %0h, none expected (cycle %0d)", guess, cyc);
        end else begin
          e = exp_q[0];
          chk("offer_kind", e.is_err, 0);
          chk("offer_guess", guess, e.val);
          if (e.cyc >= 0) chk("valid_latency", cyc, e.cyc);
        end
        offered = guess;
      end
      if (guess_valid) begin
        chk("offer_stable", guess, offered);
        chk("busy_in_offer", busy, 1);
      end
      if (guess_valid && guess_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        post_xfer = 1'b1;
      end
      if (guess_error && !eprev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_error: got code %0b, none expected (cycle %0d)", error_code, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("error_kind", e.is_err, 1);
          chk("error_code", error_code, e.code);
          chk("valid_on_error", guess_valid, 0);
          if (e.cyc >= 0) chk("error_latency", cyc, e.cyc);
        end
      end
      vprev = guess_valid;
      eprev = guess_error;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, guess_valid, 0);
    chk({tag, "_guess"}, guess, 0);
    chk({tag, "_error"}, guess_error, 0);
    chk({tag, "_code"}, error_code, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!guess_valid && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", guess_valid, 1);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_empty_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Clean step press: switches settle first, then enter held for 'hold' cycles.
  task automatic press_clean(input logic [15:0] sw, input int hold, input bit push);
    exp_t e;
    tick();
    SW = sw;
    repeat (SYN + 1) tick();
    enter = 1'b1;
    if (push) begin
      e = model(sw, cyc + SYN + DEB + 3);
      exp_q.push_back(e);
      if (e.is_err) last_code = e.code;
    end
    repeat (hold) tick();
    enter = 1'b0;
    repeat (12) tick();
  endtask

  int bounce_lvl[6] = '{1, 0, 1, 1, 0, 1};
  int bounce_len[6] = '{3, 1, 2, 1, 2, 3};

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   digs[10];
    reset = 1'b1;
    enter = 1'b0;
    SW    = '0;
    repeat (3) tick();
    check_reset_outputs("reset_init");
    reset = 1'b0;
    repeat (2) tick();

    // Clean press, ready low: offer held, then a single-cycle ready.
    rmode = 0;
    press_clean(16'h1234, 20, 1'b1);
    wait_valid(20);
    repeat (3) tick();
    chk("held_valid", guess_valid, 1);
    chk("held_guess", guess, 16'h1234);
    rmode = 1;
    tick();
    rmode = 0;
    wait_empty(20);

    // Bouncing press resolves to exactly one guess.
    rmode = 1;
    tick();
    SW = 16'h4567;
    repeat (3) tick();
    e = model(16'h4567, -1);
    exp_q.push_back(e);
    for (int i = 0; i < 6; i++) begin
      enter = bounce_lvl[i][0];
      repeat (bounce_len[i]) tick();
    end
    enter = 1'b1;
    repeat (10) tick();
    enter = 1'b0;
    repeat (12) tick();
    wait_empty(40);

    // Isolated 3-cycle pulses never register.
    repeat (3) begin
      enter = 1'b1;
      repeat (DEB - 1) tick();
      enter = 1'b0;
      repeat (6) tick();
    end
    repeat (10) tick();
    chk("short_pulse_busy", busy, 0);

    // Invalid guesses: each cause code.
    press_clean(16'h1A34, 8, 1'b1);
    press_clean(16'h1134, 8, 1'b1);
    press_clean(16'hAA12, 8, 1'b1);
    wait_empty(40);

    // Press during OFFER is dropped.
    rmode = 0;
    press_clean(16'h9870, 10, 1'b1);
    press_clean(16'h0123, 10, 1'b0);
    chk("drop_guess", guess, 16'h9870);
    chk("drop_valid", guess_valid, 1);
    chk("code_sticky", error_code, last_code);
    rmode = 1;
    tick();
    rmode = 0;
    wait_empty(20);
    repeat (20) tick();
    chk("drop_no_second", guess_valid, 0);

    // Reset while offering.
    press_clean(16'h2468, 10, 1'b1);
    wait_valid(30);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_offer");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Reset mid-debounce with enter held through deassertion.
    SW = 16'h3079;
    repeat (3) tick();
    enter = 1'b1;
    repeat (SYN + 2) tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_debounce");
    rmode = 1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.push_back(model(16'h3079, cyc + SYN + DEB + 3));
    wait_empty(40);
    enter = 1'b0;
    repeat (12) tick();

    // Ready held high: one-cycle offer.
    rmode = 1;
    press_clean(16'h5678, 10, 1'b1);
    wait_empty(40);

    // Randomised presses: half with distinct decimal digits, half raw.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] sw;
      rmode = int'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 10; k++) digs[k] = k;
        for (int k = 0; k < 4; k++) begin
          int j = int'($urandom_range(k, 9));
          int t = digs[k];
          digs[k] = digs[j];
          digs[j] = t;
        end
        sw = {digs[0][3:0], digs[1][3:0], digs[2][3:0], digs[3][3:0]};
      end else begin
        sw = 16'($urandom);
      end
      press_clean(sw, int'($urandom_range(5, 12)), 1'b1);
      wait_empty(200);
    end

    repeat (10) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
